alu_exec_sequencer: RTL and testbench
=====================================

// Module: alu_exec_sequencer
// PURPOSE
//  Issue/completion controller for the EX-stage ALU: accepts one operation per valid/ready handshake and sequences it.
//  add/sub/or/and complete in 1 cycle; mul runs on an internal iterative shift-add engine for WIDTH cycles.
//  Sits between ID/EX issue and EX/MEM writeback. Drives busy so the hazard logic stalls upstream during mul.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2); mul iteration count equals WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operation presented
//  in_ready   out  1      sequencer can accept this cycle
//  alu_ctr    in   3      000 add, 001 sub, 010 or, 011 and, 100 mul; others illegal
//  src_a      in   WIDTH  operand A
//  src_b      in   WIDTH  operand B
//  out_valid  out  1      result held valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  illegal    out  1      qualifies result: op code was illegal
//  busy       out  1      mul in progress (state MUL)
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE, out_valid=0, result=0, illegal=0, busy=0, counter=0; overrides all inputs.
//  States:
//   IDLE: accept on in_valid&&in_ready.
//   MUL:  one shift-add step per cycle.
//   DONE: out_valid=1.
//  in_ready = (state==IDLE) || (state==DONE && out_ready); combinational from state and out_ready only.
//  Accept of a non-mul op: result<=op(src_a,src_b); illegal<=(alu_ctr>3'b100); next state DONE.
//   Latency: out_valid high the cycle after the accept edge.
//  Accept of mul: latch src_a into multiplicand reg, src_b into multiplier reg; acc<=0; counter<=WIDTH; next state MUL; busy=1.
//  MUL step: if mplr[0], acc<=acc+mcand (mod 2^WIDTH); mcand<<=1; mplr>>=1; counter<=counter-1.
//   When counter reaches 1 this cycle: result<=final acc; illegal<=0; next state DONE.
//   Latency: exactly WIDTH+1 cycles from accept edge to out_valid.
//  Arithmetic:
//   add/sub wrap mod 2^WIDTH; no carry/overflow output.
//   mul returns the low WIDTH bits of the unsigned product (equal to the signed low half).
//   Illegal op: result=0, illegal=1, 1-cycle latency.
//  DONE:
//   out_valid=1; result/illegal stable until the transfer (out_valid&&out_ready).
//   On transfer with a simultaneous accept: load the new op, same rules as IDLE (back-to-back, no bubble).
//   On transfer without an accept: go to IDLE, out_valid=0; result keeps its last value.
//  Inputs are ignored in MUL and in DONE without out_ready; operand changes in MUL have no effect (latched at accept).
//  Reset during MUL or DONE: the operation is aborted and its result discarded; no out_valid pulse.
// TESTING
//  T1 add 5+7, out_ready=1 -> out_valid the cycle after accept, result=12, illegal=0, in_ready=1 throughout.
//  T2 sub 3-5 -> result=32'hFFFFFFFE; or F0|0F -> FF; and F0&3C -> 30. Issued back-to-back: one result per cycle.
//  T3 mul 32'h0000FFFF*32'h00010001 -> busy=1 and in_ready=0 for 32 cycles, out_valid at accept+33, result=32'hFFFFFFFF.
//  T4 mul (-3)*7 -> 32'hFFFFFFEB; mul x*0 -> 0 at accept+33.
//  T5 out_ready=0 for 5 cycles after add 1+1 -> out_valid/result=2 held; in_ready=0; a new in_valid is not consumed; released on out_ready=1.
//  T6 rst=1 mid-mul (cycle 10), and alu_ctr=3'b111 -> reset: IDLE, out_valid=0, result=0 next edge, no stale result later; illegal: result=0, illegal=1.

Source files
------------

// File: rtl/alu_exec_sequencer.sv
// EX-stage ALU issue/completion sequencer: single-cycle add/sub/or/and,
// iterative shift-add multiply over WIDTH cycles, valid/ready on both sides.
module alu_exec_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_ctr,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             illegal,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_OR  = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               illegal_q, illegal_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q, mplr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_MUL);
   assign result    = result_q;
   assign illegal   = illegal_q;

   // Next-state and datapath; a new accept overrides the DONE->IDLE drain.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      illegal_d = illegal_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplr_d    = mplr_q;
      cnt_d     = cnt_q;

      case (state_q)
         S_MUL: begin
            acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               result_d  = acc_d;
               illegal_d = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: ;
      endcase

      if (accept) begin
         state_d   = S_DONE;
         illegal_d = 1'b0;
         case (alu_ctr)
            OP_ADD: result_d = src_a + src_b;
            OP_SUB: result_d = src_a - src_b;
            OP_OR:  result_d = src_a | src_b;
            OP_AND: result_d = src_a & src_b;
            OP_MUL: begin
               mcand_d = src_a;
               mplr_d  = src_b;
               acc_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = S_MUL;
               illegal_d = illegal_q;
            end
            default: begin
               result_d  = '0;
               illegal_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         illegal_q <= 1'b0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         illegal_q <= illegal_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplr_q    <= mplr_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer: single-cycle ops, back-to-back,
// iterative multiply timing, backpressure, reset abort and illegal opcodes.
module tb_alu_exec_sequencer;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       alu_ctr;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             illegal;
   logic             busy;

   int n_cmp;
   int n_err;

   alu_exec_sequencer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctr   (alu_ctr),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .illegal   (illegal),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      in_valid = 1'b1;
      alu_ctr  = op;
      src_a    = a;
      src_b    = b;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; alu_ctr = 3'b000; src_a = '0; src_b = '0; out_ready = 1'b1;
      tick(); tick();
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || illegal !== 1'b0) begin
         n_err++; $display("FAIL reset_flags: out_valid=%b busy=%b illegal=%b want 0 0 0", out_valid, busy, illegal);
      end
      n_cmp++;
      if (result !== 32'h0) begin
         n_err++; $display("FAIL reset_result: got %h want 00000000", result);
      end
      rst = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_add();
      drive(3'b000, 32'd5, 32'd7);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL add_in_ready_pre: got %b want 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'd12 || illegal !== 1'b0) begin
         n_err++; $display("FAIL add_result: out_valid=%b result=%h illegal=%b want 1 0000000c 0", out_valid, result, illegal);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL add_in_ready_done: got %b want 1", in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || result !== 32'd12) begin
         n_err++; $display("FAIL add_drain: out_valid=%b result=%h want 0 0000000c", out_valid, result);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]       ops [3];
      logic [WIDTH-1:0] as  [3];
      logic [WIDTH-1:0] bs  [3];
      logic [WIDTH-1:0] exp [3];
      ops = '{3'b001, 3'b010, 3'b011};
      as  = '{32'd3, 32'hF0, 32'hF0};
      bs  = '{32'd5, 32'h0F, 32'h3C};
      exp = '{32'hFFFFFFFE, 32'hFF, 32'h30};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], as[i], bs[i]);
         tick();
         if (i == 2) in_valid = 1'b0;
         n_cmp++;
         if (out_valid !== 1'b1 || result !== exp[i] || illegal !== 1'b0) begin
            n_err++; $display("FAIL b2b_%0d: out_valid=%b result=%h illegal=%b want 1 %h 0", i, out_valid, result, illegal, exp[i]);
         end
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_mul();
      logic [WIDTH-1:0] as  [5];
      logic [WIDTH-1:0] bs  [5];
      logic [WIDTH-1:0] exp [5];
      as  = '{32'h0000FFFF, 32'hFFFFFFFD, 32'h12345678, 32'hFFFFFFFF, 32'd6};
      bs  = '{32'h00010001, 32'd7,        32'h0,        32'hFFFFFFFF, 32'd7};
      exp = '{32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0,        32'h00000001, 32'd42};
      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         drive(3'b100, as[v], bs[v]);
         tick();
         in_valid = 1'b0;
         // Scramble operands during the multiply; the engine must use latched values.
         src_a = 32'hA5A5A5A5; src_b = 32'h5A5A5A5A;
         for (int c = 0; c < 32; c++) begin
            n_cmp++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
               n_err++; $display("FAIL mul%0d_busy_c%0d: busy=%b in_ready=%b out_valid=%b want 1 0 0", v, c, busy, in_ready, out_valid);
            end
            tick();
         end
         n_cmp++;
         if (out_valid !== 1'b1 || busy !== 1'b0 || result !== exp[v] || illegal !== 1'b0) begin
            n_err++; $display("FAIL mul%0d_result: out_valid=%b busy=%b result=%h illegal=%b want 1 0 %h 0", v, out_valid, busy, result, illegal, exp[v]);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(3'b000, 32'd1, 32'd1);
      tick();
      drive(3'b001, 32'd9, 32'd1);
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_hold_c%0d: out_valid=%b result=%h in_ready=%b want 1 00000002 0", c, out_valid, result, in_ready);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || result !== 32'd2) begin
         n_err++; $display("FAIL bp_release: out_valid=%b result=%h want 0 00000002", out_valid, result);
      end
   endtask

   task automatic test_reset_mid_mul();
      logic seen;
      out_ready = 1'b1;
      drive(3'b100, 32'd3, 32'd4);
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 9; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL rst_mul: out_valid=%b busy=%b result=%h illegal=%b in_ready=%b want 0 0 0 0 1", out_valid, busy, result, illegal, in_ready);
      end
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL rst_mul_stale: stale activity seen=%b want 0", seen);
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      drive(3'b000, 32'd10, 32'd20);
      tick();
      drive(3'b111, 32'hDEADBEEF, 32'h1);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'h0 || illegal !== 1'b1) begin
         n_err++; $display("FAIL illegal_111: out_valid=%b result=%h illegal=%b want 1 00000000 1", out_valid, result, illegal);
      end
      drive(3'b101, 32'd4, 32'd4);
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'h0 || illegal !== 1'b1) begin
         n_err++; $display("FAIL illegal_101: out_valid=%b result=%h illegal=%b want 1 00000000 1", out_valid, result, illegal);
      end
      drive(3'b000, 32'd2, 32'd3);
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || result !== 32'd5 || illegal !== 1'b0) begin
         n_err++; $display("FAIL illegal_clear: out_valid=%b result=%h illegal=%b want 1 00000005 0", out_valid, result, illegal);
      end
      tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_add();
      test_back_to_back();
      test_mul();
      test_backpressure();
      test_reset_mid_mul();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
